param_register_file: RTL
========================

Name: param_register_file

Overview:
- Parametrised successor to the CPU's pseudo-triple-port register file.
- Configurable data width, depth and number of read ports, plus one write port with same-cycle write-through bypass.
- Adds a sequential post-reset clear sweep with a ready flag, so large depths map to block RAM rather than flops.
- Adds a per-register pending-write scoreboard for pipelined hazard detection.
- Sits between decode (read addresses, reservations) and writeback (write port) in the VeSPA CPU.

Parameters:
DATA_W  32  register width in bits
ADDR_W  5  address width; depth = 2^ADDR_W entries
NUM_RD  2  number of independent synchronous read ports (1..4)

Ports:
i_Clk  in  1  clock; all logic on rising edge
i_Rst  in  1  synchronous, active-high reset
i_WrEnable  in  1  write strobe
i_WrAddr  in  ADDR_W  write address
i_DataIn  in  DATA_W  write data
i_ResvEn  in  1  reserve strobe; marks i_ResvAddr pending
i_ResvAddr  in  ADDR_W  register to reserve
i_RdAddr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
o_RdData  out  NUM_RD*DATA_W  registered read data; port k at bits [k*DATA_W +: DATA_W]
o_RdPend  out  NUM_RD  registered pending flag per read port
o_Ready  out  1  high when the clear sweep is complete and the file is usable

Behaviour:
- Reset (i_Rst high at clock edge):
  - FSM goes to CLEAR; sweep counter = 0.
  - Entire pending vector is cleared in that cycle.
  - o_RdData = 0, o_RdPend = 0, o_Ready = 0.
  - Holding i_Rst keeps the counter at 0. Reset asserted mid-sweep or in READY restarts the sweep from entry 0.
- CLEAR state:
  - Each cycle writes 0 to entry[counter], then counter increments.
  - After entry 2^ADDR_W-1 is written, FSM goes to READY; o_Ready rises on the following edge.
  - Sweep length is 2^ADDR_W cycles after reset deasserts (32 for the default).
  - Host writes and reservations are ignored; o_RdData and o_RdPend stay 0.
- READY state: stays here until reset.
- Reads (READY only):
  - Latency 1 cycle. o_RdData port k is loaded with entry[addr_k] at each edge.
  - Bypass: if i_WrEnable and i_WrAddr == addr_k in the same cycle, port k returns i_DataIn, not the stale entry.
  - All ports are independent; any number may read the same address.
- Writes (READY only): entry[i_WrAddr] <= i_DataIn when i_WrEnable is high.
- Scoreboard (READY only):
  - i_ResvEn sets pend[i_ResvAddr].
  - A write clears pend[i_WrAddr].
  - Same cycle, same address for reserve and write: pend ends at 1 (a new reservation wins).
  - Reserve and write to different addresses act independently.
- Pending output:
  - o_RdPend[k] is registered with o_RdData port k.
  - Value is pend[addr_k] after this cycle's write-clear, before this cycle's reserve-set.
  - So a write bypassed this cycle reports not pending, and a reservation made this cycle is not visible until the next read.
- Widths: no arithmetic beyond the sweep counter, which is ADDR_W+1 bits so it terminates without wrap.
- Out-of-range NUM_RD is a synthesis error via a generate-time check.

Optional Feature:
ZERO_REG_EN
- Defined:
  - Entry 0 is hardwired to zero: writes to address 0 are discarded and never bypassed.
  - Reads of address 0 return 0 with o_RdPend = 0.
  - Reservations of address 0 are ignored.
- Undefined: entry 0 is an ordinary register, identical to all others.

Test Plan:
- Assert i_Rst 3 cycles, release -> o_Ready low for exactly 32 cycles (default params), then high; every read port returns 0 for all addresses.
- Write 0xDEADBEEF to r7 while port 0 and port 1 both read r7 in the same cycle -> both ports show 0xDEADBEEF next cycle; a read of r7 two cycles later also shows 0xDEADBEEF.
- Reserve r5, then read r5 on the next cycle -> o_RdPend = 1; write r5 = 0x12 -> a same-cycle read shows data 0x12 with pend 0.
- Reserve and write r9 in the same cycle -> the following read of r9 shows pend 1 and the new data.
- Write r3 = 0xA5, pulse i_Rst mid-operation, and issue writes during the sweep -> sweep restarts, the writes are ignored, and r3 reads 0 after o_Ready rises.
- With ZERO_REG_EN defined: write r0 = 0xFFFFFFFF with a same-cycle read of r0 -> read returns 0, pend 0; without the macro -> read returns 0xFFFFFFFF.

Source files
------------

// File: rtl/param_register_file.sv
// param_register_file: parametrised register file with NUM_RD synchronous read ports,
// one write port with same-cycle write-through, post-reset clear sweep and a
// per-register pending-write scoreboard.
// Ports: i_Clk/i_Rst (sync, active-high); i_WrEnable/i_WrAddr/i_DataIn write port;
// i_ResvEn/i_ResvAddr reserve port; i_RdAddr packed read addresses;
// o_RdData/o_RdPend registered read data and pending flags; o_Ready sweep done.
// Optional: define ZERO_REG_EN to hardwire entry 0 to zero.
module param_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_WrEnable,
  input  logic [ADDR_W-1:0]        i_WrAddr,
  input  logic [DATA_W-1:0]        i_DataIn,
  input  logic                     i_ResvEn,
  input  logic [ADDR_W-1:0]        i_ResvAddr,
  input  logic [NUM_RD*ADDR_W-1:0] i_RdAddr,
  output logic [NUM_RD*DATA_W-1:0] o_RdData,
  output logic [NUM_RD-1:0]        o_RdPend,
  output logic                     o_Ready
);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam int DEPTH = 2 ** ADDR_W;
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("param_register_file: NUM_RD must be 1..4");
  end
  logic [0:0]        state;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend, pend_clr;
  logic              rdy, we, re;
  assign rdy = state == READY;
  assign o_Ready = rdy;
`ifdef ZERO_REG_EN
  // Entry 0 never accepts writes or reservations, so the sweep's zero sticks.
  assign we = rdy && i_WrEnable && |i_WrAddr;
  assign re = rdy && i_ResvEn && |i_ResvAddr;
`else
  assign we = rdy && i_WrEnable;
  assign re = rdy && i_ResvEn;
`endif
  // Pending view after this cycle's write-clear but before this cycle's reserve-set.
  always_comb begin
    pend_clr = pend;
    if (we) pend_clr[i_WrAddr] = 1'b0;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= CLEAR;
      cnt   <= '0;
      pend  <= '0;
    end else if (!rdy) begin
      cnt <= cnt + 1'b1;
      if (cnt == {1'b0, {ADDR_W{1'b1}}}) state <= READY;
    end else begin
      pend <= pend_clr;
      if (re) pend[i_ResvAddr] <= 1'b1;
    end
  end
  // Single write port shared by the sweep and the host keeps the array RAM-mappable.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst && (!rdy || we)) mem[rdy ? i_WrAddr : cnt[ADDR_W-1:0]] <= rdy ? i_DataIn : '0;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst || !rdy) begin
      o_RdData <= '0;
      o_RdPend <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        o_RdData[k*DATA_W +: DATA_W] <= (we && i_WrAddr == i_RdAddr[k*ADDR_W +: ADDR_W])
                                        ? i_DataIn : mem[i_RdAddr[k*ADDR_W +: ADDR_W]];
        o_RdPend[k] <= pend_clr[i_RdAddr[k*ADDR_W +: ADDR_W]];
      end
    end
  end
endmodule
